ram_master: RTL

Bus initiator for the active-low RAM block: accepts burst read/write commands on a valid/ready interface and drives the RAM's Address, InData, CS, WE and OE lines. It sits between the CPU-side or DMA logic and the RAM. It sequences strobes so that WE and OE are never asserted together. It streams write data in and read data out with back-pressure.

---
 rtl/ram_master_pkg.sv | 23 ++
 rtl/ram_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_master_pkg.sv
// ---------------------------------------------------------------------------
// ram_master_pkg : shared FSM state type and active-low strobe levels
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAITW = 3'd1,
    WR    = 3'd2,
    VFY   = 3'd3,
    RD    = 3'd4,
    RSP   = 3'd5
  } state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_master.sv
// ---------------------------------------------------------------------------
// ram_master : burst read/write initiator for the active-low RAM block.
// Optional readback verify of every written word: RAM_MASTER_READBACK_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_master
  import ram_master_pkg::*;
#(
  parameter int AddressSize = 16,
  parameter int WordSize    = 8,
  parameter int LenSize     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AddressSize-1:0] cmd_addr,
  input  logic [LenSize-1:0]     cmd_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WordSize-1:0]    wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WordSize-1:0]    rd_data,
  output logic                   busy,
  output logic                   err,
  output logic [AddressSize-1:0] Address,
  output logic [WordSize-1:0]    RamData,
  input  logic [WordSize-1:0]    RamQ,
  output logic                   CS,
  output logic                   WE,
  output logic                   OE
);

  state_e                 state_q, state_d;
  logic [AddressSize-1:0] addr_q, addr_d;
  logic [LenSize-1:0]     cnt_q, cnt_d;
  logic [WordSize-1:0]    ram_data_q, ram_data_d;
  logic [WordSize-1:0]    rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   busy_q, busy_d;
  logic                   last_word;
`ifdef RAM_MASTER_READBACK_EN
  logic                   err_q, err_d;
`endif

  assign last_word = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ram_data_d = ram_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
`ifdef RAM_MASTER_READBACK_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
`ifdef RAM_MASTER_READBACK_EN
          err_d   = 1'b0;
`endif
          state_d = cmd_write ? WAITW : RD;
        end
      end
      WAITW: begin
        if (wr_valid) begin
          ram_data_d = wr_data;
          state_d    = WR;
        end
      end
      WR: begin
`ifdef RAM_MASTER_READBACK_EN
        state_d = VFY;
`else
        if (last_word) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + AddressSize'(1);
          cnt_d   = cnt_q - LenSize'(1);
          state_d = WAITW;
        end
`endif
      end
`ifdef RAM_MASTER_READBACK_EN
      VFY: begin
        if (RamQ != ram_data_q) err_d = 1'b1;
        if (last_word) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + AddressSize'(1);
          cnt_d   = cnt_q - LenSize'(1);
          state_d = WAITW;
        end
      end
`endif
      RD: begin
        rd_data_d  = RamQ;
        rd_valid_d = 1'b1;
        state_d    = RSP;
      end
      RSP: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (last_word) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + AddressSize'(1);
            cnt_d   = cnt_q - LenSize'(1);
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and status decode the next state so every output leaves a flop.
  always_comb begin
    cs_d        = STROBE_OFF;
    we_d        = STROBE_OFF;
    oe_d        = STROBE_OFF;
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WAITW);
    busy_d      = (state_d != IDLE);
    case (state_d)
      WR: begin
        cs_d = STROBE_ON;
        we_d = STROBE_ON;
      end
`ifdef RAM_MASTER_READBACK_EN
      VFY: begin
        cs_d = STROBE_ON;
        oe_d = STROBE_ON;
      end
`endif
      RD: begin
        cs_d = STROBE_ON;
        oe_d = STROBE_ON;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      ram_data_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      cs_q        <= STROBE_OFF;
      we_q        <= STROBE_OFF;
      oe_q        <= STROBE_OFF;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RAM_MASTER_READBACK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ram_data_q  <= ram_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
`ifdef RAM_MASTER_READBACK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign Address   = addr_q;
  assign RamData   = ram_data_q;
  assign CS        = cs_q;
  assign WE        = we_q;
  assign OE        = oe_q;
`ifdef RAM_MASTER_READBACK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

`default_nettype wire
